seg_scan_driver: RTL and testbench

//   Time-multiplexed driver for a 4-digit common-anode 7-segment display; sits directly upstream of the
//   hex-to-segment decoder. Latches a 16-bit value and scans one digit at a time: presents that digit's

---
 rtl/seg_scan_driver_if.sv | 23 ++
 rtl/seg_scan_driver.sv | 91 +++++++++
 tb/tb_seg_scan_driver.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Bus between a display controller and the 7-segment scan driver.
// Inputs carry value/masks; outputs carry the scanned digit signals.
interface seg_scan_driver_if;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  point;
    logic [3:0]  hex;
    logic [3:0]  anode_n;
    logic        dp_n;
    logic        digit_tick;

    modport master (
        output en, load, data, blank, point,
        input  hex, anode_n, dp_n, digit_tick
    );

    modport slave (
        input  en, load, data, blank, point,
        output hex, anode_n, dp_n, digit_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with ghosting guard.
// Define LEADING_ZERO_BLANK_EN to also suppress leading zero digits.
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST    = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [CW-1:0] div_q, div_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   data_q;
    logic [3:0]    blank_q, point_q;
    logic [3:0]    hex_q, hex_d;
    logic [3:0]    anode_q, anode_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;
    logic [3:0]    supp;
    logic          wrap, lit;

    // Digits to keep dark: explicit blank mask, optionally leading zeros.
    always_comb begin
        supp = blank_q;
`ifdef LEADING_ZERO_BLANK_EN
        supp[1] = blank_q[1] | (data_q[15:4] == 12'h000);
        supp[2] = blank_q[2] | (data_q[15:8] == 8'h00);
        supp[3] = blank_q[3] | (data_q[15:12] == 4'h0);
`endif
    end

    // Divider/digit ring advance and next registered output values.
    always_comb begin
        div_d   = div_q;
        digit_d = digit_q;
        wrap    = bus.en && (div_q == LAST);
        lit     = bus.en && (div_q >= GUARD_C) && !supp[digit_q];
        hex_d   = data_q[digit_q*4 +: 4];
        anode_d = 4'b1111;
        dp_d    = 1'b1;
        tick_d  = wrap;
        if (bus.en) begin
            if (wrap) begin
                div_d   = '0;
                digit_d = digit_q + 2'd1;
            end else begin
                div_d = div_q + CW'(1);
            end
        end
        if (lit) begin
            anode_d[digit_q] = 1'b0;
            dp_d             = ~point_q[digit_q];
        end
    end

    // Scan state, latched display value and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            digit_q <= 2'd0;
            data_q  <= 16'h0000;
            blank_q <= 4'b1111;
            point_q <= 4'b0000;
            hex_q   <= 4'h0;
            anode_q <= 4'b1111;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            digit_q <= digit_d;
            hex_q   <= hex_d;
            anode_q <= anode_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
            if (bus.load) begin
                data_q  <= bus.data;
                blank_q <= bus.blank;
                point_q <= bus.point;
            end
        end
    end

    assign bus.hex        = hex_q;
    assign bus.anode_n    = anode_q;
    assign bus.dp_n       = dp_q;
    assign bus.digit_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (SCAN_DIV=4, GUARD=1).
// Reference model tracks enabled-cycle count and latched values.
module tb_seg_scan_driver;
    localparam int SD = 4;
    localparam int GD = 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_driver_if bus ();

    seg_scan_driver #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: enabled edges since reset decide slot/digit position.
    int          n_en;
    logic [15:0] m_data;
    logic [3:0]  m_blank, m_point;
    logic [3:0]  exp_hex, exp_an;
    logic        exp_dp, exp_tick;

    task automatic model_reset();
        n_en    = 0;
        m_data  = 16'h0000;
        m_blank = 4'hF;
        m_point = 4'h0;
    endtask

    function automatic bit suppressed(int d);
        logic [15:0] upper;
        upper = m_data >> (4 * d);
        return m_blank[d] || (LZB && d > 0 && upper == 16'h0);
    endfunction

    task automatic step(input logic en, input logic ld,
                        input logic [15:0] d,
                        input logic [3:0] b, input logic [3:0] p);
        int slot, dig;
        bit lit;
        logic [15:0] sh;
        bus.en    = en;
        bus.load  = ld;
        bus.data  = d;
        bus.blank = b;
        bus.point = p;
        @(posedge clk);
        slot = n_en % SD;
        dig  = (n_en / SD) % 4;
        lit  = en && slot >= GD && !suppressed(dig);
        sh   = m_data >> (4 * dig);
        exp_hex  = sh[3:0];
        exp_an   = lit ? 4'(~(4'b0001 << dig)) : 4'hF;
        exp_dp   = lit ? ~m_point[dig] : 1'b1;
        exp_tick = en && slot == SD - 1;
        if (en) n_en++;
        if (ld) begin
            m_data  = d;
            m_blank = b;
            m_point = p;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, 16'h9876, 4'h0, 4'hF);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.anode_n !== 4'hF) begin
            n_bad++;
            $display("FAIL rst_anode: got %h want f", bus.anode_n);
        end
        n_cmp++;
        if (bus.hex !== 4'h0) begin
            n_bad++;
            $display("FAIL rst_hex: got %h want 0", bus.hex);
        end
        n_cmp++;
        if (bus.dp_n !== 1'b1 || bus.digit_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_dp_tick: got %b%b want 10", bus.dp_n, bus.digit_tick);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            n_cmp++;
            if (bus.anode_n !== 4'hF) begin
                n_bad++;
                $display("FAIL dark_after_rst: got %h want f", bus.anode_n);
            end
            n_cmp++;
            if (bus.digit_tick !== exp_tick) begin
                n_bad++;
                $display("FAIL dark_tick: got %b want %b", bus.digit_tick, exp_tick);
            end
        end
    endtask

    task automatic test_scan();
        int lit_n, dp_n0, ticks;
        step(1'b1, 1'b1, 16'h12A4, 4'h0, 4'b0100);
        lit_n = 0; dp_n0 = 0; ticks = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            if (bus.anode_n != 4'hF) lit_n++;
            if (bus.dp_n == 1'b0) dp_n0++;
            if (bus.digit_tick) ticks++;
            n_cmp++;
            if (bus.hex !== exp_hex || bus.anode_n !== exp_an) begin
                n_bad++;
                $display("FAIL scan_hex_an: got %h/%h want %h/%h",
                         bus.hex, bus.anode_n, exp_hex, exp_an);
            end
            n_cmp++;
            if (bus.dp_n !== exp_dp || bus.digit_tick !== exp_tick) begin
                n_bad++;
                $display("FAIL scan_dp_tick: got %b%b want %b%b",
                         bus.dp_n, bus.digit_tick, exp_dp, exp_tick);
            end
        end
        n_cmp++;
        if (lit_n != 12 || dp_n0 != 3 || ticks != 4) begin
            n_bad++;
            $display("FAIL scan_counts: got lit=%0d dp=%0d tick=%0d want 12/3/4",
                     lit_n, dp_n0, ticks);
        end
    endtask

    task automatic test_pause();
        int guard_n = 0;
        while (n_en % 16 != 5 && guard_n < 32) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            guard_n++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
            n_cmp++;
            if (bus.anode_n !== 4'hF || bus.digit_tick !== 1'b0) begin
                n_bad++;
                $display("FAIL pause_dark: got %h/%b want f/0",
                         bus.anode_n, bus.digit_tick);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            n_cmp++;
            if (bus.anode_n !== exp_an || bus.hex !== exp_hex ||
                bus.digit_tick !== exp_tick) begin
                n_bad++;
                $display("FAIL pause_resume: got %h/%h/%b want %h/%h/%b",
                         bus.anode_n, bus.hex, bus.digit_tick,
                         exp_an, exp_hex, exp_tick);
            end
        end
        n_cmp++;
        if (bus.anode_n !== 4'b1011 && bus.anode_n !== 4'hF) begin
            n_bad++;
            $display("FAIL pause_next_digit: got %h want b or f", bus.anode_n);
        end
    endtask

    task automatic count_lit(input logic [15:0] d, input logic [3:0] b,
                             input int want, input string tag);
        int lit_n = 0, ticks = 0;
        step(1'b1, 1'b1, d, b, 4'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            if (bus.anode_n != 4'hF) lit_n++;
            if (bus.digit_tick) ticks++;
            n_cmp++;
            if (bus.anode_n !== exp_an || bus.hex !== exp_hex) begin
                n_bad++;
                $display("FAIL %s_model: got %h/%h want %h/%h",
                         tag, bus.anode_n, bus.hex, exp_an, exp_hex);
            end
        end
        n_cmp++;
        if (lit_n != want || ticks != 4) begin
            n_bad++;
            $display("FAIL %s_count: got lit=%0d tick=%0d want %0d/4",
                     tag, lit_n, ticks, want);
        end
    endtask

    task automatic test_blank();
        count_lit(16'h1234, 4'b1010, 6, "blank");
    endtask

    task automatic test_leading_zero();
        if (LZB) begin
            count_lit(16'h0050, 4'h0, 6, "lzb_0050");
            count_lit(16'h0000, 4'h0, 3, "lzb_0000");
        end else begin
            count_lit(16'h0050, 4'h0, 12, "nolzb_0050");
        end
    endtask

    task automatic test_load_on_wrap();
        int guard_n = 0;
        while (n_en % SD != SD - 1 && guard_n < 8) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
            guard_n++;
        end
        step(1'b1, 1'b1, 16'hFFFF, 4'h0, 4'h0);
        n_cmp++;
        if (bus.digit_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_tick: got %b want 1", bus.digit_tick);
        end
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        n_cmp++;
        if (bus.hex !== 4'hF) begin
            n_bad++;
            $display("FAIL wrap_hex: got %h want f", bus.hex);
        end
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        n_cmp++;
        if (bus.anode_n !== exp_an || bus.anode_n === 4'hF) begin
            n_bad++;
            $display("FAIL wrap_lit: got %h want %h", bus.anode_n, exp_an);
        end
    endtask

    task automatic test_random();
        logic en, ld;
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 11) == 0);
            step(en, ld, 16'($urandom), 4'($urandom), 4'($urandom));
            n_cmp++;
            if (bus.hex !== exp_hex || bus.anode_n !== exp_an ||
                bus.dp_n !== exp_dp || bus.digit_tick !== exp_tick) begin
                n_bad++;
                $display("FAIL rand_%0d: got %h/%h/%b/%b want %h/%h/%b/%b", i,
                         bus.hex, bus.anode_n, bus.dp_n, bus.digit_tick,
                         exp_hex, exp_an, exp_dp, exp_tick);
            end
        end
    endtask

    initial begin
        bus.en    = 1'b0;
        bus.load  = 1'b0;
        bus.data  = 16'h0;
        bus.blank = 4'h0;
        bus.point = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_scan();
        test_pause();
        test_blank();
        test_leading_zero();
        test_load_on_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
